// File: rtl/crg_capture_buffer_if.sv
// Host-side bundle for crg_capture_buffer: session control, CRG beat input,
// readout port and capture status.
interface crg_capture_buffer_if #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned N_CH       = 3,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned SKIP_MAX_W = 8
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;

    logic                     arm_i;
    logic                     stop_i;
    logic                     wrap_i;
    logic [SKIP_MAX_W-1:0]    skip_i;
    logic [ADDR_W:0]          target_i;
    logic                     dvld_i;
    logic [N_CH*DATA_W-1:0]   data_i;
    logic                     rd_en_i;
    logic [ADDR_W-1:0]        rd_addr_i;
    logic [CH_W-1:0]          rd_ch_i;
    logic [DATA_W-1:0]        rd_data_o;
    logic                     rd_vld_o;
    logic                     busy_o;
    logic                     done_o;
    logic [ADDR_W:0]          count_o;
    logic                     ovf_o;
    logic [15:0]              ovf_cnt_o;

    modport master (
        output arm_i, stop_i, wrap_i, skip_i, target_i, dvld_i, data_i,
               rd_en_i, rd_addr_i, rd_ch_i,
        input  rd_data_o, rd_vld_o, busy_o, done_o, count_o, ovf_o, ovf_cnt_o
    );

    modport slave (
        input  arm_i, stop_i, wrap_i, skip_i, target_i, dvld_i, data_i,
               rd_en_i, rd_addr_i, rd_ch_i,
        output rd_data_o, rd_vld_o, busy_o, done_o, count_o, ovf_o, ovf_cnt_o
    );
endinterface

// File: rtl/crg_capture_buffer.sv
// Capture buffer between the CRG engine and UART readout: skip, fixed-length
// or ring capture of N_CH-wide beats, with oldest-first logical readback.
module crg_capture_buffer #(
    parameter int unsigned DATA_W     = 256,
    parameter int unsigned N_CH       = 3,
    parameter int unsigned DEPTH      = 256,
    parameter int unsigned SKIP_MAX_W = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    crg_capture_buffer_if.slave    bus
);
    localparam int unsigned ADDR_W = $clog2(DEPTH);
    localparam int unsigned CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1;
    localparam int unsigned CNT_W  = ADDR_W + 1;
    localparam int unsigned BEAT_W = N_CH * DATA_W;
    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    typedef enum logic [1:0] {IDLE, SKIP, CAPT, DONE} state_t;

    state_t                state, state_nxt;
    logic [ADDR_W-1:0]     wr_ptr;
    logic [CNT_W-1:0]      count;
    logic [CNT_W-1:0]      target_q;
    logic [SKIP_MAX_W-1:0] skip_cnt;
    logic                  wrap_q;
    logic                  ovf;
    logic [15:0]           ovf_cnt;
    logic                  busy_q, done_q;
    logic [DATA_W-1:0]     rd_data_q;
    logic                  rd_vld_q;

    logic clr_c, wr_en_c, drop_c, skip_dec_c, ovf_ev_c;

    logic [BEAT_W-1:0] mem [DEPTH];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and per-cycle datapath strobes; stop outranks arm
    always_comb begin
        state_nxt  = state;
        clr_c      = 1'b0;
        wr_en_c    = 1'b0;
        drop_c     = 1'b0;
        skip_dec_c = 1'b0;
        if (bus.stop_i) begin
            if (state == SKIP || state == CAPT) state_nxt = DONE;
            else if (state == DONE)             drop_c = bus.dvld_i && !wrap_q;
        end else if (bus.arm_i) begin
            clr_c     = 1'b1;
            state_nxt = (bus.skip_i != '0) ? SKIP : CAPT;
        end else begin
            case (state)
                SKIP: if (bus.dvld_i) begin
                    skip_dec_c = 1'b1;
                    if (skip_cnt <= SKIP_MAX_W'(1)) state_nxt = CAPT;
                end
                CAPT: if (bus.dvld_i) begin
                    wr_en_c = 1'b1;
                    if (!wrap_q && (count + CNT_W'(1)) == target_q) state_nxt = DONE;
                end
                DONE:    drop_c = bus.dvld_i && !wrap_q;
                default: ;
            endcase
        end
        ovf_ev_c = drop_c || (wr_en_c && wrap_q && count == FULL);
    end

    // Session registers: pointers, counters, latched mode and status flags
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            count    <= '0;
            target_q <= '0;
            skip_cnt <= '0;
            wrap_q   <= 1'b0;
            ovf      <= 1'b0;
            ovf_cnt  <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            busy_q <= (state_nxt == SKIP) || (state_nxt == CAPT);
            done_q <= (state_nxt == DONE);
            if (clr_c) begin
                wr_ptr   <= '0;
                count    <= '0;
                ovf      <= 1'b0;
                ovf_cnt  <= '0;
                wrap_q   <= bus.wrap_i;
                skip_cnt <= bus.skip_i;
                target_q <= (bus.target_i == '0 || bus.target_i > FULL) ? FULL : bus.target_i;
            end else begin
                if (skip_dec_c) skip_cnt <= skip_cnt - SKIP_MAX_W'(1);
                if (wr_en_c) begin
                    wr_ptr <= wr_ptr + ADDR_W'(1);
                    if (count != FULL) count <= count + CNT_W'(1);
                end
                if (ovf_ev_c) begin
                    ovf <= 1'b1;
                    if (ovf_cnt != 16'hFFFF) ovf_cnt <= ovf_cnt + 16'd1;
                end
            end
        end
    end

    // Beat storage, contents deliberately left uninitialised
    always_ff @(posedge clk) begin
        if (wr_en_c) mem[wr_ptr] <= bus.data_i;
    end

    // Read path: once a ring has filled, logical 0 is the slot about to be overwritten
    logic [ADDR_W-1:0] rd_phys_c;
    logic [BEAT_W-1:0] rd_word_c;
    logic [DATA_W-1:0] rd_slice_c;
    logic              rd_in_range_c;

    assign rd_phys_c     = (wrap_q && count == FULL) ? (wr_ptr + bus.rd_addr_i) : bus.rd_addr_i;
    assign rd_word_c     = mem[rd_phys_c];
    assign rd_in_range_c = ({1'b0, bus.rd_addr_i} < count) && (32'(bus.rd_ch_i) < N_CH);

    always_comb begin
        rd_slice_c = '0;
        for (int k = 0; k < int'(N_CH); k++) begin
            if (bus.rd_ch_i == CH_W'(k)) rd_slice_c = rd_word_c[k*DATA_W +: DATA_W];
        end
    end

    // Registered read data; memory read precedes the same-cycle write
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_vld_q  <= 1'b0;
            rd_data_q <= '0;
        end else begin
            rd_vld_q <= bus.rd_en_i;
            if (bus.rd_en_i) rd_data_q <= rd_in_range_c ? rd_slice_c : '0;
        end
    end

    assign bus.rd_data_o = rd_data_q;
    assign bus.rd_vld_o  = rd_vld_q;
    assign bus.busy_o    = busy_q;
    assign bus.done_o    = done_q;
    assign bus.count_o   = count;
    assign bus.ovf_o     = ovf;
    assign bus.ovf_cnt_o = ovf_cnt;
endmodule
